dmem_access: RTL
================

// Module: dmem_access
// PURPOSE
//  Memory-stage data-bus master. Consumes the M-stage access (ALUOutM address, DataM store data,
//  SizeM/SignedM, MemWriteM, d_validM) and runs one dbus transaction per access through an FSM.
//  Returns the aligned, sign/zero-extended load result to the W-stage register and raises
//  DMemStall to freeze F..M while the bus has not answered.
// PARAMETERS
//  none (address and data are fixed at 32 bits; msize_t: MSIZE1=0, MSIZE2=1, MSIZE4=2)
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  reset        in   1   synchronous, active-high reset
//  d_validM     in   1   M-stage holds a load or store (MemtoRegM|MemWriteM)
//  MemWriteM    in   1   1=store, 0=load
//  ALUOutM      in   32  byte address
//  DataM        in   32  store data, already forwarded
//  SizeM        in   2   msize_t access size
//  SignedM      in   1   load sign-extends when 1
//  AdvanceM     in   1   pipeline moves M->W this cycle (no stall from any source)
//  dreq_valid   out  1   bus request valid
//  dreq_addr    out  32  request address (= ALUOutM)
//  dreq_size    out  2   request size (= SizeM)
//  dreq_strobe  out  4   byte write enables; 4'b0000 for loads
//  dreq_data    out  32  lane-replicated store data
//  dresp_addr_ok in  1   request accepted this cycle
//  dresp_data_ok in  1   response complete this cycle
//  dresp_data   in   32  raw read word
//  ReadDataM    out  32  extended load result
//  DMemStall    out  1   access not yet complete; freeze pipeline
//  AddrErrM     out  1   misaligned access (combinational)
// BEHAVIOUR
//  - Reset: state=IDLE, data register=0; outputs dreq_valid=0, DMemStall=0, ReadDataM=0.
//  - Misaligned: SizeM==MSIZE2 & ALUOutM[0], or SizeM==MSIZE4 & ALUOutM[1:0]!=0 -> AddrErrM=1.
//    No bus request is issued, DMemStall=0, state stays IDLE.
//  - Strobe: MSIZE1 4'b0001<<a[1:0]; MSIZE2 4'b0011<<a[1:0]; MSIZE4 4'b1111.
//  - Store data: MSIZE1 {4{DataM[7:0]}}; MSIZE2 {2{DataM[15:0]}}; MSIZE4 DataM.
//  - Load: shift dresp_data right by 8*a[1:0]; take the low 8/16/32 bits and extend by SignedM.
//  - Go condition: d_validM & ~AddrErrM.
//  - States:
//    IDLE: dreq_valid=go. If go & addr_ok & data_ok -> DONE (latch data).
//          If go & addr_ok only -> WAIT. If go & ~addr_ok -> REQ.
//    REQ:  dreq_valid=1, request fields held stable. addr_ok&data_ok -> DONE; addr_ok -> WAIT.
//    WAIT: dreq_valid=0. data_ok -> DONE (latch data).
//    DONE: dreq_valid=0; ReadDataM comes from the latched register. AdvanceM -> IDLE.
//  - DMemStall = go & ~(transition into DONE this cycle) in IDLE/REQ/WAIT; 0 in DONE.
//    The same-cycle completion path is combinational: ReadDataM = extended dresp_data that cycle.
//  - Inputs are stable while DMemStall=1 because upstream is frozen. A flush never aborts a request
//    that has been issued; the transaction drains and the result is discarded downstream.
//  - Reset mid-transaction -> IDLE immediately. The bus slave is reset in the same cycle.
//  - A new access in the cycle after DONE->IDLE issues normally; there is no idle bubble.
// TESTING
//  1 load word a=0x100, addr_ok and data_ok in the same cycle as the request, data=0xDEADBEEF
//    -> ReadDataM=0xDEADBEEF, DMemStall=0, dreq_strobe=0.
//  2 signed byte load a=0x103, data=0x80xxxxxx, addr_ok after 2 cycles and data_ok 3 cycles later
//    -> DMemStall=1 for 5 cycles, dreq_valid held 3 cycles, ReadDataM=0xFFFFFF80.
//    The same access with SignedM=0 -> ReadDataM=0x00000080.
//  3 halfword store a=0x202, DataM=0x1234ABCD -> dreq_strobe=4'b1100, dreq_data=0xABCDABCD.
//  4 word load a=0x101 -> AddrErrM=1, dreq_valid=0, DMemStall=0, state stays IDLE.
//  5 completion while AdvanceM=0 for 3 cycles -> FSM stays in DONE, ReadDataM held stable,
//    no second request issued. AdvanceM=1 -> IDLE, and the next access issues the following cycle.
//  6 reset asserted while in WAIT -> next cycle state=IDLE, DMemStall=0, dreq_valid=0.

Source files
------------

// File: rtl/dmem_access.sv
// dmem_access: memory-stage data-bus master.
// Issues one dbus transaction for each M-stage load or store and aligns the
// write strobes and store data onto the byte lanes. Loads are shifted and
// sign- or zero-extended before they go to the W-stage register. DMemStall
// freezes F..M until the bus has answered.
module dmem_access (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_validM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] DataM,
    input  logic [1:0]  SizeM,
    input  logic        SignedM,
    input  logic        AdvanceM,
    output logic        dreq_valid,
    output logic [31:0] dreq_addr,
    output logic [1:0]  dreq_size,
    output logic [3:0]  dreq_strobe,
    output logic [31:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [31:0] dresp_data,
    output logic [31:0] ReadDataM,
    output logic        DMemStall,
    output logic        AddrErrM
);

    localparam logic [1:0] MSIZE1 = 2'd0;
    localparam logic [1:0] MSIZE2 = 2'd1;
    localparam logic [1:0] MSIZE4 = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_data;

    logic        w_misalign;
    logic        w_go;
    logic        w_complete;
    logic [31:0] w_load;

    // Move the addressed byte or halfword down to bit 0, then extend it to 32 bits.
    function automatic logic [31:0] load_extend(
        input logic [31:0] raw,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        sgn
    );
        logic [31:0] sh;
        sh = raw >> {off, 3'b000};
        case (size)
            MSIZE1:  load_extend = {{24{sgn & sh[7]}}, sh[7:0]};
            MSIZE2:  load_extend = {{16{sgn & sh[15]}}, sh[15:0]};
            default: load_extend = sh;
        endcase
    endfunction

    // Byte enables for a store. A load never writes a lane.
    function automatic logic [3:0] store_strobe(
        input logic       wr,
        input logic [1:0] off,
        input logic [1:0] size
    );
        if (!wr) begin
            store_strobe = 4'b0000;
        end else begin
            case (size)
                MSIZE1:  store_strobe = 4'b0001 << off;
                MSIZE2:  store_strobe = 4'b0011 << off;
                default: store_strobe = 4'b1111;
            endcase
        end
    endfunction

    // Copy the store data onto every lane, so the strobes alone choose which bytes are written.
    function automatic logic [31:0] store_lanes(
        input logic [31:0] d,
        input logic [1:0]  size
    );
        case (size)
            MSIZE1:  store_lanes = {4{d[7:0]}};
            MSIZE2:  store_lanes = {2{d[15:0]}};
            default: store_lanes = d;
        endcase
    endfunction

    // Alignment check and the request fields. Upstream holds M steady while
    // DMemStall is high, so the request fields come straight from the inputs.
    always_comb begin
        w_misalign = 1'b0;
        if (SizeM == MSIZE2 && ALUOutM[0])
            w_misalign = 1'b1;
        else if (SizeM == MSIZE4 && ALUOutM[1:0] != 2'b00)
            w_misalign = 1'b1;
        AddrErrM    = w_misalign;
        w_go        = d_validM & ~w_misalign;
        dreq_addr   = ALUOutM;
        dreq_size   = SizeM;
        dreq_strobe = store_strobe(MemWriteM, ALUOutM[1:0], SizeM);
        dreq_data   = store_lanes(DataM, SizeM);
        w_load      = load_extend(dresp_data, ALUOutM[1:0], SizeM, SignedM);
    end

    // Next state, request valid, completion and stall.
    always_comb begin
        w_state_nxt = r_state;
        w_complete  = 1'b0;
        dreq_valid  = 1'b0;
        DMemStall   = 1'b0;
        case (r_state)
            S_IDLE: begin
                dreq_valid = w_go;
                if (w_go) begin
                    if (dresp_addr_ok && dresp_data_ok)
                        w_complete = 1'b1;
                    else if (dresp_addr_ok)
                        w_state_nxt = S_WAIT;
                    else
                        w_state_nxt = S_REQ;
                end
                DMemStall = w_go & ~w_complete;
            end
            S_REQ: begin
                dreq_valid = 1'b1;
                if (dresp_addr_ok && dresp_data_ok)
                    w_complete = 1'b1;
                else if (dresp_addr_ok)
                    w_state_nxt = S_WAIT;
                DMemStall = w_go & ~w_complete;
            end
            S_WAIT: begin
                if (dresp_data_ok)
                    w_complete = 1'b1;
                DMemStall = w_go & ~w_complete;
            end
            S_DONE: begin
                if (AdvanceM)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // DONE only holds the result while another stall source keeps this
        // access in M. If the pipeline advances in the completion cycle, the
        // next access is already in M, so the FSM goes straight back to IDLE.
        if (w_complete)
            w_state_nxt = AdvanceM ? S_IDLE : S_DONE;
    end

    // Result mux: the latched word while in DONE, the live bus word on the completion cycle.
    always_comb begin
        ReadDataM = r_data;
        if (r_state != S_DONE && w_complete)
            ReadDataM = w_load;
    end

    // State register. Reset abandons any transaction in flight; the bus slave is reset in the same cycle.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Load result register, written when the response completes.
    always_ff @(posedge clk) begin
        if (reset)
            r_data <= 32'd0;
        else if (w_complete)
            r_data <= w_load;
    end

endmodule
